asym_fifo: RTL

// - Single-clock width-converting FIFO: accepts wide words (WIDTHA), delivers narrow words (WIDTHB).

---
 rtl/asym_fifo_pkg.sv | 39 +++
 rtl/asym_fifo_ram.sv | 37 +++
 rtl/asym_fifo.sv | 131 +++++++++++++
 3 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared helpers for the width-converting FIFO: sizing functions, output-stage
// occupancy encoding and an elaboration-time parameter check.
package asym_fifo_pkg;

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_e;

  function automatic int unsigned clog2(input int unsigned v);
    for (int unsigned r = 0; r < 32; r++) begin
      if ((64'd1 << r) >= 64'(v)) return r;
    end
    return 32;
  endfunction

  function automatic bit isPow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned ratioOf(input int unsigned wa, input int unsigned wb);
    return wa / wb;
  endfunction

  function automatic int unsigned awbOf(input int unsigned depth, input int unsigned wa,
                                        input int unsigned wb);
    return clog2(depth) + clog2(wa / wb);
  endfunction

endpackage

`ifndef ASYM_FIFO_PARAM_CHECK
`define ASYM_FIFO_PARAM_CHECK(WA, WB, DA) \
  if (((WA) % (WB)) != 0 || ((WA) / (WB)) < 2 || \
      !asym_fifo_pkg::isPow2((WA) / (WB)) || !asym_fifo_pkg::isPow2(DA) || (DA) < 2) begin : gParamErr \
    $error("asym_fifo: WIDTHA must be WIDTHB*2^k (k>=1) and DEPTHA a power of two >= 2"); \
  end
`endif

// File: rtl/asym_fifo_ram.sv
// Asymmetric storage: one wide write fills RATIO consecutive narrow entries,
// narrow read port registered with one cycle of latency. No reset on contents.
module asym_fifo_ram #(
  parameter int unsigned WIDTHA    = 384,
  parameter int unsigned WIDTHB    = 48,
  parameter int unsigned AWA       = 7,
  parameter int unsigned LR        = 3,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [AWA-1:0]        wrAddr,
  input  logic [WIDTHA-1:0]     wrData,
  input  logic                  rdEn,
  input  logic [AWA+LR-1:0]     rdAddr,
  output logic [WIDTHB-1:0]     rdData
);

  localparam int unsigned RATIO = 1 << LR;
  localparam int unsigned AWB   = AWA + LR;

  logic [WIDTHB-1:0] mem [2**AWB];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        mem[{wrAddr, LR'(i)}] <=
          wrData[((MSB_FIRST != 0) ? (RATIO - 1 - i) : i) * WIDTHB +: WIDTHB];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/asym_fifo.sv
// Single-clock width-converting FIFO: wide words in, narrow words out, with a
// 2-entry skid buffer behind the registered RAM read so output runs at 1 word/cycle.
module asym_fifo
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WIDTHA    = 384,
  parameter int unsigned WIDTHB    = 48,
  parameter int unsigned DEPTHA    = 128,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned AFULL_TH  = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [WIDTHA-1:0]                         din,
  input  logic                                      din_valid,
  output logic                                      din_ready,
  output logic [WIDTHB-1:0]                         dout,
  output logic                                      dout_valid,
  input  logic                                      dout_ready,
  output logic [awbOf(DEPTHA, WIDTHA, WIDTHB):0]    level,
  output logic                                      almost_full,
  output logic                                      empty
);

  localparam int unsigned RATIO = ratioOf(WIDTHA, WIDTHB);
  localparam int unsigned LR    = clog2(RATIO);
  localparam int unsigned AWA   = clog2(DEPTHA);
  localparam int unsigned AWB   = AWA + LR;
  localparam int unsigned CAP   = DEPTHA * RATIO;

  `ASYM_FIFO_PARAM_CHECK(WIDTHA, WIDTHB, DEPTHA)

  logic [AWA:0]        wrPtr;
  logic [AWB:0]        rdPtr;
  logic [AWB:0]        ramCnt;
  logic [AWB:0]        levelNext;
  logic [AWB:0]        freeNext;
  occ_e                occ;
  logic                inflight;
  logic                wrEn;
  logic                rdEn;
  logic                pop;
  logic [WIDTHB-1:0]   rdData;
  logic [WIDTHB-1:0]   skid;

  assign ramCnt     = {wrPtr, {LR{1'b0}}} - rdPtr;
  assign level      = ramCnt + (AWB+1)'(occ) + (AWB+1)'(inflight);
  assign empty      = (level == '0);
  assign dout_valid = (occ != OCC0);
  assign pop        = dout_valid && dout_ready;

  // Capacity is judged on total occupancy, so words parked in the output
  // stage still hold their slots until the consumer takes them.
  assign din_ready  = (level <= (AWB+1)'(CAP - RATIO));
  assign wrEn       = din_valid && din_ready;

  assign rdEn = (ramCnt != '0) &&
                ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2);

  assign levelNext = level + (wrEn ? (AWB+1)'(RATIO) : '0) - (AWB+1)'(pop);
  assign freeNext  = (AWB+1)'(CAP) - levelNext;

  asym_fifo_ram #(
    .WIDTHA    (WIDTHA),
    .WIDTHB    (WIDTHB),
    .AWA       (AWA),
    .LR        (LR),
    .MSB_FIRST (MSB_FIRST)
  ) uRam (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrPtr[AWA-1:0]),
    .wrData (din),
    .rdEn   (rdEn),
    .rdAddr (rdPtr[AWB-1:0]),
    .rdData (rdData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      almost_full <= (32'(freeNext >> LR) <= AFULL_TH);
    end
  end

  // dout is the head entry, skid the second; the read issue rule guarantees
  // an arriving word never finds both occupied without a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= OCC0;
      inflight <= 1'b0;
      dout     <= '0;
      skid     <= '0;
    end else begin
      inflight <= rdEn;
      case (occ)
        OCC0: begin
          if (inflight) begin
            dout <= rdData;
            occ  <= OCC1;
          end
        end
        OCC1: begin
          case ({pop, inflight})
            2'b11: dout <= rdData;
            2'b10: occ  <= OCC0;
            2'b01: begin
              skid <= rdData;
              occ  <= OCC2;
            end
            default: ;
          endcase
        end
        OCC2: begin
          if (pop) begin
            dout <= skid;
            if (inflight) skid <= rdData;
            else          occ  <= OCC1;
          end
        end
        default: occ <= OCC0;
      endcase
    end
  end

endmodule
